memory_responder: RTL

- Byte-wide memory and I/O responder sitting on the target side of the control unit's memory interface. The control unit's MAR and write strobes drive the request; this block returns the byte that becomes from_memory.
- Serves one request at a time through a req/ack handshake with a configurable read/write latency.
- Decodes the 8-bit address into a ROM region, a RAM region and memory-mapped I/O ports.
- Provides a program-load port so benches and boot logic can preload ROM contents.

---
 rtl/memory_responder.sv | 83 ++++++++
 1 files changed

// File: rtl/memory_responder.sv
// memory_responder: byte-wide ROM/RAM/I/O target with a req/ack handshake,
// configurable access latency and a program-load port for preloading the array.
module memory_responder #(
   parameter int          LATENCY      = 1,
   parameter logic [7:0]  IN_PORT_ADDR = 8'hF8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic [7:0] address,
   input  logic [7:0] wdata,
   input  logic       write,
   output logic [7:0] rdata,
   output logic       ack,
   output logic       busy,
   output logic       wr_err,
   input  logic [7:0] port_in_a,
   output logic [7:0] port_out_a,
   output logic [7:0] port_out_b,
   input  logic       prog_we,
   input  logic [7:0] prog_addr,
   input  logic [7:0] prog_data
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [2:0] LAST = 3'(LATENCY - 1);
   state_t state, state_n;
   logic [2:0] count, count_n;
   logic [7:0] addr_q, wdata_q, read_val;
   logic       write_q, accept, commit, is_mem, is_ram;
   logic [7:0] mem [256];
   assign busy   = (state == ACCESS) || prog_we;
   assign accept = req && !busy;
   assign commit = (state == ACCESS) && (count == LAST);
   assign ack    = (state == RESP);
   assign is_mem = addr_q < 8'hF0;
   assign is_ram = addr_q[7] && is_mem;
   assign read_val = is_mem                  ? mem[addr_q] :
                     addr_q == 8'hF0         ? port_out_a :
                     addr_q == 8'hF1         ? port_out_b :
                     addr_q == IN_PORT_ADDR  ? port_in_a  : 8'h00;
   always_comb begin
      state_n = state;
      count_n = count + 3'd1;
      if (state == ACCESS) state_n = commit ? RESP : ACCESS;
      else begin
         state_n = accept ? ACCESS : IDLE;
         count_n = 3'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= 3'd0;
         rdata      <= 8'h00;
         port_out_a <= 8'h00;
         port_out_b <= 8'h00;
         wr_err     <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         if (commit && !write_q) rdata <= read_val;
         if (commit && write_q) begin
            if (addr_q == 8'hF0) port_out_a <= wdata_q;
            else if (addr_q == 8'hF1) port_out_b <= wdata_q;
            else if (!is_ram) wr_err <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= address;
         wdata_q <= wdata;
         write_q <= write;
      end
   end
   // Program loads only happen outside ACCESS, so they never collide with a commit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (prog_we && state != ACCESS) mem[prog_addr] <= prog_data;
         else if (commit && write_q && is_ram) mem[addr_q] <= wdata_q;
      end
   end
endmodule
